// File: rtl/dma_service_fsm.sv
`default_nettype none
// ============================================================================
// Module      : dma_service_fsm
// Description : Service sequencer for a four-channel DMA controller. Raises
//               the hold request, waits for the CPU hold acknowledge and then
//               walks each transfer through the address (S1), read (S2),
//               write (S3) and retire (S4) cycles. Single, block and demand
//               modes are supported, as are read, write and verify transfers.
//               Optional macro DMA_COMPRESSED_TIMING_EN removes S3 so that a
//               transfer goes S2 -> S4 with the write strobe only in S4.
// Revision    : 1.0  initial release
// ============================================================================
module dma_service_fsm #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [3:0]             DREQ,
    input  logic                   HLDA,
    input  logic [3:0]             DACK,
    input  logic                   controllerDisable,
    input  logic [1:0]             transferMode,
    input  logic [1:0]             transferType,
    input  logic [COUNT_WIDTH-1:0] currentWordCount,
    input  logic                   addrCarry,
    output logic                   HRQ,
    output logic                   assertDACK,
    output logic                   AEN,
    output logic                   ADSTB,
    output logic                   MEMR_N,
    output logic                   MEMW_N,
    output logic                   IOR_N,
    output logic                   IOW_N,
    output logic                   EOP_N,
    output logic                   decrementCount,
    output logic                   stepAddress,
    output logic [3:0]             activeChannel
);

    localparam logic [2:0] c_SI = 3'd0;
    localparam logic [2:0] c_S0 = 3'd1;
    localparam logic [2:0] c_S1 = 3'd2;
    localparam logic [2:0] c_S2 = 3'd3;
    localparam logic [2:0] c_S3 = 3'd4;
    localparam logic [2:0] c_S4 = 3'd5;

    localparam logic [1:0] c_MODE_DEMAND = 2'b00;
    localparam logic [1:0] c_TYPE_WRITE  = 2'b01;
    localparam logic [1:0] c_TYPE_READ   = 2'b10;

    logic [2:0] r_state;
    logic [2:0] w_nextState;
    logic [3:0] r_activeChannel;
    logic       r_channelLatched;
    logic       w_terminalCount;
    logic       w_singleMode;
    logic       w_channelStillRequesting;
    logic       w_readPhase;
    logic       w_writePhase;
    logic       w_isWrite;
    logic       w_isRead;

    assign w_terminalCount          = (currentWordCount == '0);
    // Mode 11 behaves as single, so bit 0 alone identifies single mode.
    assign w_singleMode             = transferMode[0];
    assign w_channelStillRequesting = |(DREQ & r_activeChannel);
    assign w_isWrite                = (transferType == c_TYPE_WRITE);
    assign w_isRead                 = (transferType == c_TYPE_READ);

    // State register; reset dominates every other input.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= c_SI;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Channel latch: capture the grant on the first S1 of a service, clear
    // whenever the service ends so an aborted S1 leaves nothing behind.
    always_ff @(posedge CLK) begin
        if (RESET || (w_nextState == c_SI)) begin
            r_activeChannel  <= 4'b0000;
            r_channelLatched <= 1'b0;
        end else if ((r_state == c_S1) && !r_channelLatched) begin
            r_activeChannel  <= DACK;
            r_channelLatched <= 1'b1;
        end
    end

    // Next-state logic.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_SI: begin
                if (!controllerDisable && (DREQ != 4'b0000)) begin
                    w_nextState = c_S0;
                end
            end
            c_S0: begin
                if (HLDA) begin
                    w_nextState = c_S1;
                end else if (DREQ == 4'b0000) begin
                    w_nextState = c_SI;
                end
            end
            c_S1: begin
                w_nextState = HLDA ? c_S2 : c_SI;
            end
            c_S2: begin
                if (!HLDA) begin
                    w_nextState = c_SI;
                end else begin
`ifdef DMA_COMPRESSED_TIMING_EN
                    w_nextState = c_S4;
`else
                    w_nextState = c_S3;
`endif
                end
            end
            c_S3: begin
                w_nextState = HLDA ? c_S4 : c_SI;
            end
            c_S4: begin
                if (w_terminalCount || w_singleMode || !HLDA) begin
                    w_nextState = c_SI;
                end else if ((transferMode == c_MODE_DEMAND) && !w_channelStillRequesting) begin
                    w_nextState = c_SI;
                end else begin
                    // A carry into the upper address byte needs a fresh S1 strobe.
                    w_nextState = addrCarry ? c_S1 : c_S2;
                end
            end
            default: begin
                w_nextState = c_SI;
            end
        endcase
    end

    // Output decode from the current state (Moore), EOP also qualified by TC.
    always_comb begin
        w_readPhase = (r_state == c_S2) || (r_state == c_S3) || (r_state == c_S4);
`ifdef DMA_COMPRESSED_TIMING_EN
        w_writePhase = (r_state == c_S4);
`else
        w_writePhase = (r_state == c_S3) || (r_state == c_S4);
`endif
        HRQ            = (r_state != c_SI);
        assertDACK     = (r_state != c_SI) && (r_state != c_S0);
        AEN            = assertDACK;
        ADSTB          = (r_state == c_S1);
        MEMR_N         = !(w_readPhase && w_isRead);
        IOR_N          = !(w_readPhase && w_isWrite);
        IOW_N          = !(w_writePhase && w_isRead);
        MEMW_N         = !(w_writePhase && w_isWrite);
        decrementCount = (r_state == c_S4);
        stepAddress    = (r_state == c_S4);
        EOP_N          = !((r_state == c_S4) && w_terminalCount);
        activeChannel  = r_activeChannel;
    end

endmodule
`default_nettype wire

// File: tb/tb_dma_service_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_dma_service_fsm
// Description : Bench for dma_service_fsm: directed service scenarios followed
//               by randomized traffic, all checked cycle by cycle against a
//               transaction-phase reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_dma_service_fsm;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [3:0]  DREQ = 4'b0;
    logic        HLDA = 1'b0;
    logic [3:0]  DACK = 4'b0;
    logic        controllerDisable = 1'b0;
    logic [1:0]  transferMode = 2'b01;
    logic [1:0]  transferType = 2'b10;
    logic [15:0] currentWordCount = 16'd5;
    logic        addrCarry = 1'b0;
    logic        HRQ, assertDACK, AEN, ADSTB;
    logic        MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N;
    logic        decrementCount, stepAddress;
    logic [3:0]  activeChannel;

    dma_service_fsm #(.COUNT_WIDTH(16)) dut (
        .CLK(CLK), .RESET(RESET), .DREQ(DREQ), .HLDA(HLDA), .DACK(DACK),
        .controllerDisable(controllerDisable), .transferMode(transferMode),
        .transferType(transferType), .currentWordCount(currentWordCount),
        .addrCarry(addrCarry), .HRQ(HRQ), .assertDACK(assertDACK), .AEN(AEN),
        .ADSTB(ADSTB), .MEMR_N(MEMR_N), .MEMW_N(MEMW_N), .IOR_N(IOR_N),
        .IOW_N(IOW_N), .EOP_N(EOP_N), .decrementCount(decrementCount),
        .stepAddress(stepAddress), .activeChannel(activeChannel)
    );

    always #5 CLK = ~CLK;

`ifdef DMA_COMPRESSED_TIMING_EN
    localparam bit COMPRESSED = 1'b1;
`else
    localparam bit COMPRESSED = 1'b0;
`endif

    // Service phases of the reference model: idle, waiting for hold,
    // address, read, write, retire.
    localparam int P_IDLE = 0, P_REQ = 1, P_ADDR = 2, P_READ = 3, P_WRITE = 4, P_RETIRE = 5;

    int       mPhase = P_IDLE;
    bit [3:0] mChan = 4'b0;
    bit       mLatched = 1'b0;
    int       vectors = 0;
    int       miscompares = 0;
    int       decSeen = 0, eopSeen = 0, adstbSeen = 0, memwSeen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic modelStep();
        int nxt;
        nxt = mPhase;
        if (RESET) begin
            nxt = P_IDLE;
        end else begin
            case (mPhase)
                P_IDLE:  if (!controllerDisable && DREQ != 0) nxt = P_REQ;
                P_REQ:   if (HLDA) nxt = P_ADDR; else if (DREQ == 0) nxt = P_IDLE;
                P_ADDR: begin
                    if (!mLatched) begin mChan = DACK; mLatched = 1'b1; end
                    nxt = HLDA ? P_READ : P_IDLE;
                end
                P_READ:  nxt = !HLDA ? P_IDLE : (COMPRESSED ? P_RETIRE : P_WRITE);
                P_WRITE: nxt = HLDA ? P_RETIRE : P_IDLE;
                default: begin
                    if (currentWordCount == 0 || transferMode[0] || !HLDA) nxt = P_IDLE;
                    else if (transferMode == 2'b00 && (DREQ & mChan) == 0) nxt = P_IDLE;
                    else nxt = addrCarry ? P_ADDR : P_READ;
                end
            endcase
        end
        if (nxt == P_IDLE) begin
            mChan = 4'b0;
            mLatched = 1'b0;
        end
        mPhase = nxt;
    endtask

    function automatic logic [14:0] expectVec();
        bit busy, rd, wr, isW, isR, ret;
        busy = (mPhase >= P_ADDR);
        rd   = (mPhase >= P_READ);
        wr   = COMPRESSED ? (mPhase == P_RETIRE) : (mPhase >= P_WRITE);
        isW  = (transferType == 2'b01);
        isR  = (transferType == 2'b10);
        ret  = (mPhase == P_RETIRE);
        return {mPhase != P_IDLE, busy, busy, mPhase == P_ADDR,
                !(rd && isR), !(wr && isW), !(rd && isW), !(wr && isR),
                !(ret && currentWordCount == 0), ret, ret, mChan};
    endfunction

    task automatic tick();
        @(posedge CLK);
        modelStep();
        #1;
        check("outputs", {HRQ, assertDACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N, IOW_N,
                          EOP_N, decrementCount, stepAddress, activeChannel}, expectVec());
        if (decrementCount) decSeen++;
        if (!EOP_N) eopSeen++;
        if (ADSTB) adstbSeen++;
        if (!MEMW_N) memwSeen++;
    endtask

    task automatic clearSeen();
        decSeen = 0; eopSeen = 0; adstbSeen = 0; memwSeen = 0;
    endtask

    task automatic runUntilIdle(input int limit);
        int k;
        k = 0;
        do begin
            tick();
            k++;
        end while (mPhase != P_IDLE && k < limit);
        check("returnToIdle_HRQ", HRQ, 1'b0);
    endtask

    task automatic setup(input logic [1:0] mode, input logic [1:0] ttype,
                         input logic [3:0] req, input logic [15:0] cnt);
        transferMode = mode; transferType = ttype; DREQ = req; DACK = req;
        currentWordCount = cnt; addrCarry = 1'b0; HLDA = 1'b0;
        controllerDisable = 1'b0; clearSeen();
    endtask

    initial begin
        // Reset state.
        RESET = 1'b1;
        tick();
        tick();
        check("reset_HRQ", HRQ, 1'b0);
        check("reset_strobes", {MEMR_N, MEMW_N, IOR_N, IOW_N, EOP_N}, 5'h1F);
        RESET = 1'b0;

        // Single read on channel 1, hold granted on the second cycle.
        setup(2'b01, 2'b10, 4'b0010, 16'd5);
        tick();
        HLDA = 1'b1;
        runUntilIdle(20);
        check("single_decPulses", decSeen, 1);
        check("single_eopPulses", eopSeen, 0);
        check("single_adstbPulses", adstbSeen, 1);

        // Block write, count 1 then 0, no carry: second beat skips S1.
        setup(2'b10, 2'b01, 4'b0001, 16'd1);
        tick();
        HLDA = 1'b1;
        for (int k = 0; k < 20 && !(decSeen == 1 && mPhase != P_RETIRE); k++) tick();
        currentWordCount = 16'd0;
        runUntilIdle(20);
        check("block_decPulses", decSeen, 2);
        check("block_eopPulses", eopSeen, 1);
        check("block_adstbPulses", adstbSeen, 1);

        // Demand mode: request withdrawn during the second S2.
        setup(2'b00, 2'b10, 4'b0001, 16'd10);
        HLDA = 1'b1;
        for (int k = 0; k < 20 && !(decSeen == 1 && mPhase == P_READ); k++) tick();
        DREQ = 4'b0000;
        runUntilIdle(20);
        check("demand_decPulses", decSeen, 2);

        // Disabled controller ignores requests.
        setup(2'b01, 2'b10, 4'b0001, 16'd3);
        controllerDisable = 1'b1;
        HLDA = 1'b1;
        repeat (3) tick();
        check("disabled_HRQ", HRQ, 1'b0);
        // Hold lost in S2 aborts with no register-file update.
        controllerDisable = 1'b0;
        for (int k = 0; k < 20 && mPhase != P_READ; k++) tick();
        HLDA = 1'b0;
        tick();
        check("abort_HRQ", HRQ, 1'b0);
        check("abort_decPulses", decSeen, 0);

        // Reset in the middle of a transfer.
        setup(2'b01, 2'b01, 4'b0100, 16'd2);
        HLDA = 1'b1;
        for (int k = 0; k < 20 && mPhase != (COMPRESSED ? P_READ : P_WRITE); k++) tick();
        RESET = 1'b1;
        tick();
        check("midReset_HRQ", HRQ, 1'b0);
        check("midReset_strobes", {MEMR_N, MEMW_N, IOR_N, IOW_N}, 4'hF);
        check("midReset_channel", activeChannel, 4'b0000);
        RESET = 1'b0;

        // Single write: write strobe length shows whether S3 was traversed.
        setup(2'b01, 2'b01, 4'b1000, 16'd4);
        HLDA = 1'b1;
        runUntilIdle(20);
        check("write_memwCycles", memwSeen, COMPRESSED ? 1 : 2);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            RESET             = ($urandom_range(0, 99) == 0);
            controllerDisable = ($urandom_range(0, 7) == 0);
            DREQ              = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            HLDA              = (mPhase != P_IDLE) ? ($urandom_range(0, 19) != 0) : 1'b0;
            DACK              = 4'b0001 << $urandom_range(0, 3);
            transferMode      = 2'($urandom);
            transferType      = 2'($urandom);
            currentWordCount  = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom_range(1, 5));
            addrCarry         = 1'($urandom_range(0, 1));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
